mux81_scan_seq: RTL and testbench

//   Channel-scan sequencer that sits upstream of the mux81 8:1 bit mux.
//   It drives the mux's 3-bit sel in ascending order, waits a programmable settle time,
//   and samples the mux output. The eight sampled bits are assembled into a byte and

---
 rtl/mux81_scan_seq_if.sv | 14 +
 rtl/mux81_scan_seq.sv | 103 ++++++++++
 tb/tb_mux81_scan_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mux81_scan_seq_if.sv
// Bus between the scan sequencer and its surroundings: start/mask request,
// the mux81 select/output pair, and the assembled result with valid/busy.
interface mux81_scan_seq_if;
  logic       start;
  logic [7:0] mask;
  logic       mux_out;
  logic [2:0] sel;
  logic [7:0] data;
  logic       valid;
  logic       busy;

  modport master (output start, mask, mux_out, input sel, data, valid, busy);
  modport slave  (input start, mask, mux_out, output sel, data, valid, busy);
endinterface

// File: rtl/mux81_scan_seq.sv
// Channel-scan sequencer for an 8:1 bit mux: steps sel 0..7, settles, samples
// enabled channels into a byte and pulses valid when the scan completes.
module mux81_scan_seq #(
  parameter int SETTLE = 2
) (
  input logic             clk,
  input logic             rst,
  mux81_scan_seq_if.slave bus
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_CNT = CW'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t        state;
  logic [2:0]    ch;
  logic [2:0]    sel_q;
  logic [CW-1:0] cnt;
  logic [7:0]    mask_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          busy_q;

  // Skipped channels cost one cycle; enabled ones hold sel for SETTLE+1 cycles
  // before the SAMPLE cycle. Channel 7 always exits to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ch      <= '0;
      sel_q   <= '0;
      cnt     <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mask_q <= bus.mask;
            data_q <= '0;
            ch     <= '0;
            sel_q  <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!mask_q[ch]) begin
            data_q[ch] <= 1'b0;
            if (ch == 3'd7) begin
              valid_q <= 1'b1;
              state   <= ST_DONE;
            end else begin
              ch    <= ch + 3'd1;
              sel_q <= ch + 3'd1;
              cnt   <= '0;
              state <= ST_SETTLE;
            end
          end else if (cnt == SETTLE_CNT) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SAMPLE: begin
          data_q[ch] <= bus.mux_out;
          if (ch == 3'd7) begin
            valid_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            ch    <= ch + 3'd1;
            sel_q <= ch + 3'd1;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sel   = sel_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux81_scan_seq.sv
// Bench for mux81_scan_seq: two instances (SETTLE=2 and SETTLE=0) each feeding
// a behavioural mux81; results compared against a timing/data reference model.
module tb_mux81_scan_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dpat = 8'h89;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  mux81_scan_seq_if ifA ();
  mux81_scan_seq_if ifB ();

  assign ifA.mux_out = dpat[ifA.sel];
  assign ifB.mux_out = dpat[ifB.sel];

  mux81_scan_seq #(.SETTLE(2)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  mux81_scan_seq #(.SETTLE(0)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, " A.sel"},   {29'd0, ifA.sel}, 32'd0);
    checkOutput({tag, " A.data"},  {24'd0, ifA.data}, 32'd0);
    checkOutput({tag, " A.valid"}, {31'd0, ifA.valid}, 32'd0);
    checkOutput({tag, " A.busy"},  {31'd0, ifA.busy}, 32'd0);
    checkOutput({tag, " B.sel"},   {29'd0, ifB.sel}, 32'd0);
    checkOutput({tag, " B.busy"},  {31'd0, ifB.busy}, 32'd0);
  endtask

  // Model: channel n occupies SETTLE+2 cycles if enabled, else 1; result = mask & D.
  task automatic applyStimulus(input int which, input logic [7:0] m, input logic [7:0] d,
                               input bit scrambleMask);
    int st;
    int startAt[9];
    int lat;
    int expSel;
    logic [7:0] expData;
    logic [2:0] s;
    logic [7:0] dat;
    logic v, b;
    st = (which == 0) ? 2 : 0;
    startAt[0] = 0;
    for (int n = 0; n < 8; n++) startAt[n+1] = startAt[n] + (m[n] ? st + 2 : 1);
    lat = startAt[8];
    expData = m & d;

    @(negedge clk);
    dpat = d;
    if (which == 0) begin ifA.start = 1'b1; ifA.mask = m; end
    else            begin ifB.start = 1'b1; ifB.mask = m; end
    @(posedge clk);
    #1;
    ifA.start = 1'b0;
    ifB.start = 1'b0;
    if (scrambleMask) begin ifA.mask = ~m; ifB.mask = ~m; end

    for (int t = 0; t <= lat + 1; t++) begin
      s   = (which == 0) ? ifA.sel   : ifB.sel;
      dat = (which == 0) ? ifA.data  : ifB.data;
      v   = (which == 0) ? ifA.valid : ifB.valid;
      b   = (which == 0) ? ifA.busy  : ifB.busy;
      expSel = 7;
      for (int n = 7; n >= 0; n--) if (t < lat && t >= startAt[n] && t < startAt[n+1]) expSel = n;
      checkOutput($sformatf("sel m=%02h t=%0d", m, t), {29'd0, s}, expSel);
      checkOutput($sformatf("valid m=%02h t=%0d", m, t), {31'd0, v}, {31'd0, (t == lat)});
      checkOutput($sformatf("busy m=%02h t=%0d", m, t), {31'd0, b}, {31'd0, (t <= lat)});
      if (t >= lat) checkOutput($sformatf("data m=%02h t=%0d", m, t), {24'd0, dat}, {24'd0, expData});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int validAt[$];
    int lat;
    ifA.start = 1'b0; ifA.mask = 8'h00;
    ifB.start = 1'b0; ifB.mask = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkIdleReset("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed scans");
    applyStimulus(0, 8'hFF, 8'h89, 1'b0);
    applyStimulus(0, 8'h0F, 8'h89, 1'b1);
    applyStimulus(0, 8'h00, 8'h89, 1'b0);
    applyStimulus(1, 8'hFF, 8'h89, 1'b0);

    $display("[TB] start held for three scans");
    @(negedge clk);
    ifA.start = 1'b1;
    ifA.mask  = 8'hFF;
    for (int t = 0; t <= 101; t++) begin
      @(posedge clk);
      #1;
      if (ifA.valid) validAt.push_back(t);
    end
    ifA.start = 1'b0;
    checkOutput("held valid count", validAt.size(), 32'd3);
    if (validAt.size() == 3) begin
      checkOutput("held gap1", validAt[1] - validAt[0], 32'd34);
      checkOutput("held gap2", validAt[2] - validAt[1], 32'd34);
      checkOutput("held first", validAt[0], 32'd32);
    end
    repeat (3) @(posedge clk);

    $display("[TB] reset mid-scan");
    @(negedge clk);
    dpat = 8'h89;
    ifA.start = 1'b1;
    ifA.mask  = 8'hFF;
    ifB.start = 1'b1;
    ifB.mask  = 8'hFF;
    @(posedge clk);
    #1;
    ifA.start = 1'b0;
    ifB.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("partial data before rst", {24'd0, ifA.data}, 32'h01);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkIdleReset("midscan rst");
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ifA.valid || ifB.valid) lat++;
    end
    checkOutput("no valid after abort", lat, 32'd0);
    applyStimulus(0, 8'hFF, 8'h89, 1'b0);

    $display("[TB] randomized scans");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i % 2, 8'($urandom), 8'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
